// File: rtl/selftrigger_readout_arbiter_pkg.sv
// Shared types and constants for the self-trigger readout arbiter.
// Holds the FSM states, the holdoff width and the default sizes.
package selftrigger_pkg;

    localparam int NCH_DEF    = 8;
    localparam int HOLD_W     = 12;
    localparam int MISS_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // A channel index is kept at least one bit wide, even for a single channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/selftrigger_readout_arbiter_if.sv
// Readout handshake between the arbiter (master) and the frame builder (slave).
interface selftrigger_readout_arbiter_if
    import selftrigger_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int TS_W = 64
) ();
    localparam int IDX_W = idx_width(NCH);

    logic             req;
    logic             ack;
    logic [IDX_W-1:0] req_ch;
    logic [TS_W-1:0]  req_ts;

    modport master (output req, req_ch, req_ts, input ack);
    modport slave  (input req, req_ch, req_ts, output ack);

endinterface

// File: rtl/selftrigger_rr_pick.sv
// Round-robin search: first set bit of pending_i at or after rr_ptr_i, wrapping around.
module selftrigger_rr_pick
    import selftrigger_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    localparam int IDX_W = idx_width(NCH)
) (
    input  logic [NCH-1:0]   pending_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        pos_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr_i} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NCH)) begin
                pos = pos - (IDX_W + 1)'(NCH);
            end
            pos_idx = pos[IDX_W-1:0];
            if (pending_i[pos_idx]) begin
                found_o = 1'b1;
                idx_o   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/selftrigger_readout_arbiter.sv
// Per-channel self-trigger edge detection, dead time and timestamp capture,
// with a round-robin req/ack arbiter towards the shared frame builder.
module selftrigger_readout_arbiter
    import selftrigger_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int TS_W   = 64,
    parameter int MISS_W = MISS_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NCH-1:0]      ch_enable,
    input  logic [HOLD_W-1:0]   holdoff,
    input  logic [NCH-1:0]      trig_in,
    input  logic [TS_W-1:0]     ts,
    selftrigger_readout_arbiter_if.master rd,
    output logic [NCH-1:0]      pending,
    output logic [MISS_W-1:0]   missed_cnt,
    output logic [NCH-1:0]      missed_ch
);

    localparam int IDX_W = idx_width(NCH);

    logic [NCH-1:0]    trig_q, trig_prev_q, det_q;
    logic [TS_W-1:0]   ts_q, ts_det_q;
    logic [TS_W-1:0]   ts_lat_q [NCH];
    logic [NCH-1:0]    pending_q, pending_d;
    logic [MISS_W-1:0] missed_cnt_q, missed_cnt_d;
    logic [NCH-1:0]    missed_ch_q, missed_ch_d;
    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [IDX_W-1:0]  req_ch_q, req_ch_d;
    logic [TS_W-1:0]   req_ts_q, req_ts_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NCH-1:0]    hold_zero, detect, accept, drop;
    logic [NCH-1:0]    grant_clr, keep_mask;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [MISS_W:0]   miss_sum;

    // Detections are decided one stage after the registered edge, so ts travels alongside.
    assign detect = det_q & ch_enable & {NCH{enable}};
    assign accept = detect & ~pending_q & hold_zero;
    assign drop   = detect & ~accept;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_hold
        logic [HOLD_W-1:0] hold_cnt_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                hold_cnt_q <= '0;
            end else if (accept[gi]) begin
                hold_cnt_q <= holdoff;
            end else if (hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end
        end

        assign hold_zero[gi] = (hold_cnt_q == '0);
    end

    selftrigger_rr_pick #(.NCH(NCH)) u_pick (
        .pending_i (pending_q & ch_enable),
        .rr_ptr_i  (rr_ptr_q),
        .found_o   (pick_found),
        .idx_o     (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        req_ch_d  = req_ch_q;
        req_ts_d  = req_ts_q;
        rr_ptr_d  = rr_ptr_q;
        grant_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = REQ;
                    req_d    = 1'b1;
                    req_ch_d = pick_idx;
                    req_ts_d = ts_lat_q[pick_idx];
                end
            end
            REQ: begin
                if (rd.ack) begin
                    state_d             = IDLE;
                    req_d               = 1'b0;
                    grant_clr[req_ch_q] = 1'b1;
                    rr_ptr_d = (req_ch_q == IDX_W'(NCH - 1)) ? '0 : req_ch_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Disabling a channel flushes its queued request unless it is already on the bus.
    always_comb begin
        keep_mask = ch_enable;
        if (state_q == REQ) begin
            keep_mask[req_ch_q] = 1'b1;
        end
        pending_d   = (pending_q & keep_mask & ~grant_clr) | accept;
        missed_ch_d = missed_ch_q | drop;
        miss_sum    = {1'b0, missed_cnt_q};
        for (int i = 0; i < NCH; i++) begin
            miss_sum = miss_sum + (MISS_W + 1)'(drop[i]);
        end
        missed_cnt_d = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q       <= '0;
            trig_prev_q  <= '0;
            det_q        <= '0;
            ts_q         <= '0;
            ts_det_q     <= '0;
            pending_q    <= '0;
            missed_cnt_q <= '0;
            missed_ch_q  <= '0;
            state_q      <= IDLE;
            req_q        <= 1'b0;
            req_ch_q     <= '0;
            req_ts_q     <= '0;
            rr_ptr_q     <= '0;
        end else begin
            trig_q       <= trig_in;
            trig_prev_q  <= trig_q;
            det_q        <= trig_q & ~trig_prev_q;
            ts_q         <= ts;
            ts_det_q     <= ts_q;
            pending_q    <= pending_d;
            missed_cnt_q <= missed_cnt_d;
            missed_ch_q  <= missed_ch_d;
            state_q      <= state_d;
            req_q        <= req_d;
            req_ch_q     <= req_ch_d;
            req_ts_q     <= req_ts_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (accept[i]) begin
                ts_lat_q[i] <= ts_det_q;
            end
        end
    end

    assign rd.req     = req_q;
    assign rd.req_ch  = req_ch_q;
    assign rd.req_ts  = req_ts_q;
    assign pending    = pending_q;
    assign missed_cnt = missed_cnt_q;
    assign missed_ch  = missed_ch_q;

endmodule

// File: tb/tb_selftrigger_readout_arbiter.sv
// Directed bench for selftrigger_readout_arbiter: latency, round-robin order,
// dead time, drop counting with saturation, channel disable and reset mid-request.
module tb_selftrigger_readout_arbiter;

    localparam int NCH    = 8;
    localparam int TS_W   = 64;
    localparam int MISS_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NCH-1:0]    ch_enable;
    logic [11:0]       holdoff;
    logic [NCH-1:0]    trig_in;
    logic [TS_W-1:0]   ts;
    logic [NCH-1:0]    pending;
    logic [MISS_W-1:0] missed_cnt;
    logic [NCH-1:0]    missed_ch;

    int checks   = 0;
    int failures = 0;

    selftrigger_readout_arbiter_if #(.NCH(NCH), .TS_W(TS_W)) rd_if ();

    selftrigger_readout_arbiter #(.NCH(NCH), .TS_W(TS_W), .MISS_W(MISS_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .ch_enable  (ch_enable),
        .holdoff    (holdoff),
        .trig_in    (trig_in),
        .ts         (ts),
        .rd         (rd_if),
        .pending    (pending),
        .missed_cnt (missed_cnt),
        .missed_ch  (missed_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ts = ts + 64'd1;
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (rd_if.req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (rd_if.req !== 1'b1) begin
            check_val("req_timeout", {63'd0, rd_if.req}, 64'd1);
        end else begin
            $display("grant ch=%0d ts=%0d", rd_if.req_ch, rd_if.req_ts);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int  exp_req [9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
    int  exp_ch  [9] = '{0, 0, 0, 1, 0, 5, 0, 6, 0};
    int  grants;
    bit  saw_ch4;

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        ch_enable  = '1;
        holdoff    = 12'd0;
        trig_in    = '0;
        ts         = '0;
        rd_if.ack  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_val("rst_req",     {63'd0, rd_if.req}, 64'd0);
        check_val("rst_req_ch",  64'(rd_if.req_ch), 64'd0);
        check_val("rst_req_ts",  rd_if.req_ts, 64'd0);
        check_val("rst_pending", 64'(pending), 64'd0);
        check_val("rst_missed",  64'(missed_cnt), 64'd0);
        check_val("rst_miss_ch", 64'(missed_ch), 64'd0);

        // Single trigger on ch 3, 3-cycle latency, ack two cycles after req
        holdoff    = 12'd20;
        ts         = 64'd1000;
        trig_in[3] = 1'b1;
        repeat (3) tick();
        check_val("t1_pending_set", 64'(pending), 64'h08);
        check_val("t1_req_early",   {63'd0, rd_if.req}, 64'd0);
        tick();
        check_val("t1_req_lat3",    {63'd0, rd_if.req}, 64'd1);
        check_val("t1_req_ch",      64'(rd_if.req_ch), 64'd3);
        check_val("t1_req_ts",      rd_if.req_ts, 64'd1000);
        $display("grant ch=%0d ts=%0d", rd_if.req_ch, rd_if.req_ts);
        repeat (2) tick();
        check_val("t1_req_held",    {63'd0, rd_if.req}, 64'd1);
        rd_if.ack = 1'b1;
        tick();
        rd_if.ack  = 1'b0;
        trig_in[3] = 1'b0;
        check_val("t1_req_drop",    {63'd0, rd_if.req}, 64'd0);
        check_val("t1_pending_clr", 64'(pending), 64'd0);
        check_val("t1_missed",      64'(missed_cnt), 64'd0);

        // Channels 1, 5, 6 together with ack tied high: 1, 5, 6 with gaps
        pulse_reset();
        holdoff   = 12'd0;
        rd_if.ack = 1'b1;
        trig_in   = 8'h62;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_val($sformatf("t2_req_c%0d", k + 1), {63'd0, rd_if.req}, 64'(exp_req[k]));
            if (exp_req[k] == 1) begin
                check_val($sformatf("t2_ch_c%0d", k + 1), 64'(rd_if.req_ch), 64'(exp_ch[k]));
                $display("grant ch=%0d ts=%0d", rd_if.req_ch, rd_if.req_ts);
            end
        end
        trig_in = '0;
        tick();
        // rr_ptr is now 7, so ch 7 wins over ch 0
        trig_in = 8'h81;
        wait_req(10);
        check_val("t2_rrptr7_first", 64'(rd_if.req_ch), 64'd7);
        tick();
        wait_req(10);
        check_val("t2_rrptr7_second", 64'(rd_if.req_ch), 64'd0);
        tick();
        trig_in   = '0;
        rd_if.ack = 1'b0;
        tick();

        // Ch 2 dead time: retrigger at +10 dropped, at +60 accepted
        holdoff = 12'd50;
        grants  = 0;
        for (int k = 0; k < 70; k++) begin
            trig_in[2] = (k < 3) || (k >= 10 && k < 13) || (k >= 60 && k < 63);
            rd_if.ack  = rd_if.req;
            if (rd_if.req) begin
                grants++;
                $display("grant ch=%0d ts=%0d", rd_if.req_ch, rd_if.req_ts);
                check_val($sformatf("t3_grant%0d_ch", grants), 64'(rd_if.req_ch), 64'd2);
            end
            tick();
        end
        rd_if.ack = 1'b0;
        check_val("t3_grants",   64'(grants), 64'd2);
        check_val("t3_missed",   64'(missed_cnt), 64'd1);
        check_val("t3_miss_ch",  64'(missed_ch), 64'h04);
        check_val("t3_pending",  64'(pending), 64'd0);

        // Ch 0 re-fires while its request waits, holdoff 0
        holdoff    = 12'd0;
        trig_in[0] = 1'b1;
        repeat (4) tick();
        check_val("t4_req",      {63'd0, rd_if.req}, 64'd1);
        check_val("t4_req_ch",   64'(rd_if.req_ch), 64'd0);
        trig_in[0] = 1'b0;
        tick();
        trig_in[0] = 1'b1;
        repeat (3) tick();
        check_val("t4_missed",   64'(missed_cnt), 64'd2);
        check_val("t4_pending0", 64'(pending[0]), 64'd1);
        check_val("t4_req_held", {63'd0, rd_if.req}, 64'd1);
        trig_in[0] = 1'b0;
        rd_if.ack  = 1'b1;
        tick();
        rd_if.ack  = 1'b0;
        check_val("t4_pending_clr", 64'(pending), 64'd0);

        // Saturation: push missed_cnt to 0xFFFE, then 4 simultaneous drops
        pulse_reset();
        trig_in = 8'hFF;
        repeat (6) tick();
        check_val("t5_all_pending", 64'(pending), 64'hFF);
        for (int k = 0; k < 8191; k++) begin
            trig_in = '0;
            tick();
            trig_in = 8'hFF;
            tick();
        end
        repeat (2) tick();
        check_val("t5_missed_bulk", 64'(missed_cnt), 64'd65528);
        trig_in = '0;
        tick();
        trig_in = 8'h3F;
        repeat (3) tick();
        check_val("t5_missed_fffe", 64'(missed_cnt), 64'hFFFE);
        trig_in = '0;
        tick();
        trig_in = 8'h0F;
        repeat (3) tick();
        check_val("t5_missed_sat",  64'(missed_cnt), 64'hFFFF);
        check_val("t5_miss_ch",     64'(missed_ch), 64'hFF);
        trig_in = '0;

        // Disable ch 4 while it is queued behind the ch 0 request
        ch_enable = 8'hEF;
        tick();
        check_val("t5_pending4_clr", 64'(pending), 64'hEF);
        rd_if.ack = 1'b1;
        grants    = 0;
        saw_ch4   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rd_if.req) begin
                grants++;
                if (rd_if.req_ch == 3'd4) saw_ch4 = 1'b1;
                $display("grant ch=%0d ts=%0d", rd_if.req_ch, rd_if.req_ts);
            end
            tick();
        end
        rd_if.ack = 1'b0;
        check_val("t5_drain_grants", 64'(grants), 64'd7);
        check_val("t5_no_ch4",       {63'd0, saw_ch4}, 64'd0);
        check_val("t5_drained",      64'(pending), 64'd0);

        // Reset while a request is on the bus
        ch_enable  = '1;
        trig_in[5] = 1'b1;
        repeat (4) tick();
        check_val("t6_req_before", {63'd0, rd_if.req}, 64'd1);
        reset   = 1'b1;
        trig_in = '0;
        tick();
        reset   = 1'b0;
        check_val("t6_req",      {63'd0, rd_if.req}, 64'd0);
        check_val("t6_req_ch",   64'(rd_if.req_ch), 64'd0);
        check_val("t6_req_ts",   rd_if.req_ts, 64'd0);
        check_val("t6_pending",  64'(pending), 64'd0);
        check_val("t6_missed",   64'(missed_cnt), 64'd0);
        check_val("t6_miss_ch",  64'(missed_ch), 64'd0);
        tick();
        ts         = 64'd5000;
        trig_in[6] = 1'b1;
        repeat (3) tick();
        check_val("t6_req_early", {63'd0, rd_if.req}, 64'd0);
        tick();
        check_val("t6_req_lat3",  {63'd0, rd_if.req}, 64'd1);
        check_val("t6_req_ch6",   64'(rd_if.req_ch), 64'd6);
        check_val("t6_req_ts",    rd_if.req_ts, 64'd5000);
        $display("grant ch=%0d ts=%0d", rd_if.req_ch, rd_if.req_ts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/selftrigger_readout_arbiter.md
# selftrigger_readout_arbiter

Shares the single frame-builder/readout path between the per-channel self-trigger discriminators of one AFE. Each channel's `trigger` output is a level that can stay high for several cycles. For every channel the block edge-detects that level, applies a per-channel dead time, latches the timestamp at detection, and queues one pending request. Queued requests are granted round-robin to the frame builder over a req/ack handshake. Dropped triggers are counted for slow control.

## Interface
Parameters:
- `NCH`, 8: number of discriminator channels.
- `TS_W`, 64: timestamp width.
- `MISS_W`, 16: width of the missed-trigger counter.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: global accept enable.
- `ch_enable`, in, NCH: per-channel accept enable.
- `holdoff`, in, 12: dead time in cycles per channel, static while running.
- `trig_in`, in, NCH: discriminator trigger levels.
- `ts`, in, TS_W: free-running timestamp.
- `ack`, in, 1: frame builder accepts the current request.
- `req`, out, 1: request valid.
- `req_ch`, out, clog2(NCH): channel of the current request.
- `req_ts`, out, TS_W: timestamp latched at detection.
- `pending`, out, NCH: per-channel queued flags.
- `missed_cnt`, out, MISS_W: saturating count of dropped triggers.
- `missed_ch`, out, NCH: sticky per-channel dropped flag; cleared only by reset.

## Operation
- `trig_in` and `ts` are registered once. A detection is a rising edge of the registered `trig_in[i]`.
- Detection on channel i is acted on only when `enable` and `ch_enable[i]` are both high. Otherwise it is ignored and not counted.
- Accepted detection: requires `pending[i]==0` and `hold_cnt[i]==0`. Sets `pending[i]`, latches `ts_q[i]` from the registered `ts`, and loads `hold_cnt[i]` with `holdoff`.
- Dropped detection: `pending[i]==1` or `hold_cnt[i]!=0`. Increments `missed_cnt` (saturates at all-ones) and sets `missed_ch[i]`.
- Several channels dropping in the same cycle: `missed_cnt` adds the popcount of the dropping channels, saturating.
- `hold_cnt[i]` decrements by 1 per cycle while nonzero. `holdoff==0` means only pending-gating applies.
- FSM state IDLE: if any `pending` is set, pick the first set bit at or after `rr_ptr`, wrapping around. Register `req=1`, `req_ch`, `req_ts`. Go to REQ.
- FSM state REQ: `req`, `req_ch` and `req_ts` are held stable. When `ack` is high on a clock edge:
  - clear `pending[req_ch]`;
  - set `rr_ptr` to `req_ch+1` modulo NCH;
  - deassert `req` next cycle;
  - return to IDLE.
- `ack` while in IDLE is ignored.
- A detection on the channel being acknowledged in the ack cycle counts as a drop, because pending is still set that cycle.
- `ch_enable[i]` low clears `pending[i]`, except for the channel currently in REQ. That request completes normally.
- `enable` low blocks new detections only. Pending requests continue to drain.
- Reset mid-request: `req` drops on the next edge. No ack is expected afterwards.

## Timing
- Reset values: `req`=0, `req_ch`=0, `req_ts`=0, `pending`=0, `missed_cnt`=0, `missed_ch`=0, `rr_ptr`=0, all `hold_cnt`=0, state IDLE.
- `trig_in` rises before edge t:
  - edge t+1: registered;
  - edge t+2: `pending` set;
  - edge t+3: `req` high.
  - Latency is 3 cycles with an idle arbiter.
- `req_ts` equals the `ts` value present before edge t.
- Ack sampled at edge a: `req`=0 after edge a; the next `req` rises after edge a+1. There is a minimum one-cycle gap between requests.
- Sustained throughput is one grant per 2 cycles with `ack` tied high.
- `hold_cnt` loaded at edge t+2 reaches 0 `holdoff` cycles later. A new edge is accepted once `hold_cnt` is 0.

## Structure
- Shared package `selftrigger_pkg`: `NCH` default, FSM state enum (IDLE, REQ), holdoff width constant (12), `MISS_W`.
- Sub-module `selftrigger_rr_pick`: combinational round-robin first-set search. Inputs: pending vector and `rr_ptr`. Outputs: `found` and `idx`.
- Everything else is in the top: edge detect, hold counters, timestamp registers, FSM, counters.

## Test plan
- Single trigger on ch 3 with `ts`=1000 before edge t, `holdoff`=20, `ack` 2 cycles after `req`: `req` high from t+3, `req_ch`=3, `req_ts`=1000, `pending`=0 after the ack; `missed_cnt`=0.
- Channels 1, 5 and 6 rise together, `rr_ptr`=0, `ack` tied high: grants in order 1, 5, 6 with a one-cycle gap between requests; `rr_ptr` ends at 7.
- Ch 2 retriggers 10 cycles after an accepted edge with `holdoff`=50: dropped, `missed_cnt`=1, `missed_ch[2]`=1. Ch 2 retriggers 60 cycles after the first edge: accepted.
- Ch 0 re-fires while its request is unacknowledged and `holdoff`=0: `missed_cnt` increments and `pending[0]` stays 1.
- Drive `missed_cnt` to 0xFFFE, then 4 channels drop simultaneously: `missed_cnt`=0xFFFF. `ch_enable[4]` low while ch 4 is pending but not requested: `pending[4]` clears and no request is issued for ch 4.
- Assert `reset` while `req` is high: after the edge all outputs are 0 and a trigger 2 cycles later is granted with normal latency.
